// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_decoder
// Brief   : ASCII command stream -> 34-bit {sub, data} words for the WB master.
// Rev     : 1.0  initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_cmd_stb,
  output logic [33:0] o_cmd_word,
  input  logic        i_cmd_busy,
  output logic        o_err,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIGITS = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  localparam logic [3:0] C_MAX_CNT = 4'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic [1:0]  sub_q, sub_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stb_q, stb_d;
  logic [33:0] word_q, word_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  w_upper;
  logic        w_is_letter, w_is_hex, w_is_term, w_is_space;
  logic [1:0]  w_letter_sub;
  logic [3:0]  w_nibble;

  // Fold a-z onto A-Z so letters and hex digits decode case-insensitively.
  always_comb begin
    w_upper = i_rx_data;
    if (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) begin
      w_upper = i_rx_data & 8'hDF;
    end
  end

  always_comb begin
    w_is_letter  = 1'b1;
    w_letter_sub = 2'b00;
    case (w_upper)
      8'h52:   w_letter_sub = 2'b00;
      8'h57:   w_letter_sub = 2'b01;
      8'h50:   w_letter_sub = 2'b10;
      8'h53:   w_letter_sub = 2'b11;
      default: w_is_letter  = 1'b0;
    endcase
  end

  assign w_is_hex   = (w_upper >= 8'h30 && w_upper <= 8'h39) ||
                      (w_upper >= 8'h41 && w_upper <= 8'h46);
  assign w_nibble   = (w_upper <= 8'h39) ? w_upper[3:0] : (w_upper[3:0] + 4'd9);
  assign w_is_term  = (i_rx_data == 8'h0A) || (i_rx_data == 8'h0D);
  assign w_is_space = (i_rx_data == 8'h20);

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    word_d  = word_q;
    err_d   = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_stb) begin
          if (w_is_letter) begin
            sub_d   = w_letter_sub;
            acc_d   = 32'd0;
            cnt_d   = 4'd0;
            state_d = S_DIGITS;
          end else if (!w_is_term && !w_is_space) begin
            err_d = 1'b1;
          end
        end
      end
      S_DIGITS: begin
        if (i_rx_stb && !w_is_space) begin
          if (w_is_hex) begin
            // Read carries no operand, so any digit after R is a syntax error.
            if (sub_q == 2'b00 || cnt_q == C_MAX_CNT) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              acc_d = {acc_q[27:0], w_nibble};
              cnt_d = cnt_q + 4'd1;
            end
          end else if (w_is_term) begin
            word_d  = {sub_q, acc_q};
            stb_d   = 1'b1;
            state_d = S_EMIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        ovf_d = i_rx_stb;
        if (!i_cmd_busy) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sub_q   <= 2'b00;
      acc_q   <= 32'd0;
      cnt_q   <= 4'd0;
      stb_q   <= 1'b0;
      word_q  <= 34'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      word_q  <= word_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_cmd_stb  = stb_q;
  assign o_cmd_word = word_q;
  assign o_err      = err_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Converts the ASCII byte stream from the UART receiver into 34-bit command words {sub[1:0], data[31:0]} for the Wishbone master's command channel.
- Sits between the UART RX core (byte strobe) and the Wishbone master (i_cmd_stb / i_cmd_word / o_cmd_busy).
- Command syntax: one command letter, then 0..MAX_DIGITS hex digits, then a terminator.
- Holds one decoded word until the master accepts it; reports syntax errors and dropped bytes.

Parameters:
- MAX_DIGITS, 8, maximum number of hex digits accepted per command (legal range 1..8).

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_stb  in  1  one-cycle strobe: i_rx_data holds a valid received byte.
- i_rx_data  in  8  received ASCII byte.
- o_cmd_stb  out  1  command word valid; connects to the master's i_cmd_stb.
- o_cmd_word  out  34  {sub[33:32], data[31:0]}; connects to the master's i_cmd_word.
- i_cmd_busy  in  1  master cannot accept a word; connects to the master's o_cmd_busy.
- o_err  out  1  one-cycle pulse on a syntax error.
- o_overflow  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; o_cmd_stb=0; o_cmd_word=0; o_err=0; o_overflow=0.
  - Digit count=0; accumulator=0.
  - A reset mid-command or mid-hold discards everything, with no strobe.
- Character classes:
  - Command letters are case-insensitive: R/r -> sub 2'b00 (read), W/w -> 2'b01 (write), P/p -> 2'b10 (set address), S/s -> 2'b11 (special).
  - Hex digits: 0-9, A-F, a-f.
  - Terminators: 0x0A, 0x0D.
  - Space (0x20) is ignored in every state.
  - Every other byte is invalid.
- IDLE:
  - Command letter -> latch sub, clear accumulator and count, go to DIGITS.
  - Terminator or space -> ignored.
  - Hex digit or invalid byte -> o_err pulse; stay in IDLE.
- DIGITS:
  - Hex digit with count<MAX_DIGITS -> accumulator = {acc[27:0], nibble}; count+1.
  - Hex digit with count==MAX_DIGITS -> o_err pulse; discard; go to IDLE.
  - Hex digit after R -> o_err pulse; go to IDLE. Read takes no operand.
  - Terminator -> load o_cmd_word={sub, accumulator}; go to EMIT. An empty operand gives data=0.
  - Command letter or invalid byte -> o_err pulse; discard; go to IDLE. The letter is not reinterpreted.
- EMIT:
  - o_cmd_stb=1 from the cycle after the terminator is accepted (latency: 1 clock).
  - o_cmd_word is stable while o_cmd_stb=1.
  - Transfer happens on a rising edge with o_cmd_stb=1 and i_cmd_busy=0; the next cycle has o_cmd_stb=0 and state=IDLE.
  - i_cmd_busy high -> hold indefinitely.
  - Any i_rx_stb while in EMIT, including the transfer cycle -> byte dropped, o_overflow pulse next cycle, state unaffected.
- o_err and o_overflow are registered, exactly 1 cycle wide per event, and never both high from one byte.
- The accumulator is 32 bits; digits shift in at LSB. Fewer than 8 digits give zero-extension.
- o_cmd_word holds its last value when o_cmd_stb=0.
- At most one word is in flight; there is no internal FIFO.

Test Plan:
- Bytes "P1F\n", busy=0 -> one o_cmd_stb pulse with o_cmd_word=34'h2_0000001F, 1 cycle after the 0x0A byte.
- Bytes "w12345678\r" -> word 34'h1_12345678. Then "r\n" -> word 34'h0_00000000. Then "S\n" -> 34'h3_00000000.
- Bytes "W123456789\n" -> o_err pulse on the 9th digit, no o_cmd_stb. The following "R\n" decodes normally.
- Bytes "Wab", byte 'x', bytes "\n", then "R5\n":
  - One o_err pulse at 'x'; the "\n" is ignored.
  - One o_err pulse at '5'.
  - No strobe from either sequence.
- "W7\n" with i_cmd_busy=1 for 10 cycles, sending "P2\n" during the hold:
  - o_cmd_stb held 10+ cycles with word 34'h1_00000007 stable.
  - 3 o_overflow pulses.
  - Exactly one transfer after busy falls.
  - No address word is emitted.
- Assert i_reset during DIGITS ("W12") and again during EMIT -> all outputs 0 immediately, no strobe. A subsequent "P3\n" yields 34'h2_00000003.
